// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// ALU select codes, operation codes, FSM states and the result selector.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = 5;

  // Select codes understood by the alu
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Operation codes on the op input; 2'b11 is reserved and yields 0
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Picks the architectural result for the finished operation
  function automatic logic [XLEN_DEF-1:0] select_result(
    input logic [1:0]          op,
    input logic [XLEN_DEF-1:0] acc,
    input logic [XLEN_DEF-1:0] quo,
    input logic [XLEN_DEF-1:0] rem
  );
    logic [XLEN_DEF-1:0] res;
    case (op)
      OP_MUL:  res = acc;
      OP_DIVU: res = quo;
      OP_REMU: res = rem;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// The core side is the master, the unit is the slave.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU shared in form with the core's main ALU.
// Only AND, OR, ADD and SUB are implemented; other selects give 0.
module alu
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluSel,
  output logic [WIDTH-1:0] y
);

  // Operation decode
  always_comb begin
    y = '0;
    case (aluSel)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU unit. One iteration per cycle for ITER
// cycles, every add/subtract goes through the single private alu.
// Multiply is shift-add on the low word; divide is restoring
// shift-subtract, which naturally gives q=all-ones, rem=dividend on /0.
// Only XLEN=32 (equal to the alu width) is supported.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // Multiply working registers
  logic [XLEN-1:0]   acc_reg, acc_next;
  logic [XLEN-1:0]   mcand_reg, mcand_next;
  logic [XLEN-1:0]   mplier_reg, mplier_next;

  // Divide working registers
  logic [XLEN-1:0]   quo_reg, quo_next;
  logic [XLEN-1:0]   rem_reg, rem_next;
  logic [XLEN-1:0]   divisor_reg, divisor_next;

  // Registered outputs
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [XLEN-1:0]   result_reg, result_next;

  // ALU hookup
  logic [3:0]        alu_sel;
  logic [XLEN-1:0]   alu_a, alu_b, alu_y;

  // Divide step helpers: shifted partial remainder and the bit shifted out
  logic [XLEN-1:0]   rsh;
  logic              carry;
  logic              take;

  assign rsh   = {rem_reg[XLEN-2:0], quo_reg[XLEN-1]};
  assign carry = rem_reg[XLEN-1];
  // With the carry set the true 33-bit remainder exceeds any divisor
  assign take  = carry | (rsh >= divisor_reg);

  alu #(.WIDTH(XLEN)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .aluSel (alu_sel),
    .y      (alu_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for ITER cycles, one DONE cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (cnt_reg == LAST_CNT) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ALU operand steering; ADD of zeros whenever no iteration is running
  always_comb begin
    alu_sel = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (state_reg == S_RUN) begin
      if (op_reg == OP_MUL) begin
        alu_a = acc_reg;
        alu_b = mcand_reg;
      end else if (op_reg == OP_DIVU || op_reg == OP_REMU) begin
        alu_sel = ALU_SUB;
        alu_a   = rsh;
        alu_b   = divisor_reg;
      end
    end
  end

  // Datapath next values and registered output values
  always_comb begin
    op_next      = op_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    divisor_next = divisor_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          op_next      = bus.op;
          cnt_next     = '0;
          acc_next     = '0;
          mcand_next   = bus.opa;
          mplier_next  = bus.opb;
          quo_next     = bus.opa;
          rem_next     = '0;
          divisor_next = bus.opb;
        end
      end
      S_RUN: begin
        // Counter saturates at the last iteration instead of wrapping
        if (cnt_reg != LAST_CNT) cnt_next = cnt_reg + 1'b1;
        if (op_reg == OP_MUL) begin
          if (mplier_reg[0]) acc_next = alu_y;
          mcand_next  = {mcand_reg[XLEN-2:0], 1'b0};
          mplier_next = {1'b0, mplier_reg[XLEN-1:1]};
        end else if (op_reg == OP_DIVU || op_reg == OP_REMU) begin
          quo_next = {quo_reg[XLEN-2:0], take};
          rem_next = take ? alu_y : rsh;
        end
      end
      default: ;
    endcase

    busy_next   = (state_next != S_IDLE);
    done_next   = (state_reg == S_RUN) && (state_next == S_DONE);
    result_next = done_next ? select_result(op_reg, acc_next, quo_next, rem_next)
                            : result_reg;
  end

  // Working registers and outputs; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= OP_MUL;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      op_reg      <= op_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      divisor_reg <= divisor_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      result_reg  <= result_next;
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq against a behavioural model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00: begin p = 64'(a) * 64'(b); return p[31:0]; end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Issue one op, follow it to done, check latency, busy span, result, pulse width
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int lat = 0;
    int busy_cnt = 0;
    logic [31:0] exp = 32'h0;
    @(negedge clk);
    bus.op = op; bus.opa = a; bus.opb = b; bus.start = 1'b1;
    sb.push_back(model(op, a, b));
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (inject && (k == 5 || k == 20 || k == 33)) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.opa   = $urandom;
        bus.opb   = $urandom;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        lat = k;
        exp = sb.pop_front();
        check({tag, "_result"}, bus.result, exp);
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    if (lat == 0 && sb.size() > 0) exp = sb.pop_front();
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_result_held"}, bus.result, exp);
    $display("op %0d a=%h b=%h -> result=%h latency=%0d [%s]", op, a, b, bus.result, lat, tag);
  endtask

  initial begin
    int nodone;
    logic [31:0] rb;
    bus.start = 1'b0; bus.op = 2'b00; bus.opa = '0; bus.opb = '0;

    // Reset state
    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply
    run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 1'b0);
    run_op("mul_ffff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_ovf", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0);

    // Divide / remainder
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("remu_carry", OP_REMU, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_carry", OP_DIVU, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);

    // Divide by zero
    run_op("divu_by0", OP_DIVU, 32'd1234, 32'd0, 1'b0);
    run_op("remu_by0", OP_REMU, 32'd1234, 32'd0, 1'b0);

    // Reserved op
    run_op("op_rsvd", OP_RSVD, 32'd55, 32'd66, 1'b0);

    // Starts while busy and in the DONE cycle are ignored
    run_op("mul_inject", OP_MUL, 32'd1000, 32'd3, 1'b1);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    bus.op = OP_MUL; bus.opa = 32'hDEAD_BEEF; bus.opb = 32'h1234_5677; bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midrun_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_result", bus.result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nodone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) nodone++;
    end
    check("no_done_after_reset", 32'(nodone), 32'd0);
    run_op("mul_3x5", OP_MUL, 32'd3, 32'd5, 1'b0);

    // Random ops against the model
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
